jtdd_sdram: RTL and testbench



---
 rtl/jtdd_sdram_pkg.sv | 40 ++++
 rtl/jtdd_sdram_wait.sv | 29 ++
 rtl/jtdd_sdram.sv | 223 ++++++++++++++++++++++
 tb/tb_jtdd_sdram.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_sdram_pkg.sv
// Shared definitions for the SDRAM responder: command encodings, mode word, FSM states.
package jtdd_sdram_pkg;

  // Commands as {ncs, nras, ncas, nwe}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  // Burst length 2, sequential, CL=2
  localparam logic [12:0] MODE_REG = 13'b000_0_00_010_0_001;

  localparam int unsigned WAIT_W = 16;

  typedef enum logic [3:0] {
    StInitWait,
    StInitPre,
    StInitRef1,
    StInitRef2,
    StMrs,
    StIdle,
    StAct,
    StRead,
    StData0,
    StData1,
    StWrite,
    StWrite2,
    StRef,
    StWait
  } state_e;

  // READ/WRITE address: A10 set for auto-precharge, column in the low bits
  function automatic logic [12:0] col_addr(input logic [8:0] col);
    return {3'b001, 1'b0, col};
  endfunction

endpackage

// File: rtl/jtdd_sdram_wait.sv
// Loadable down-counter shared by every timed wait in the SDRAM FSM.
module jtdd_sdram_wait
  import jtdd_sdram_pkg::*;
#(
  parameter int unsigned ResetVal = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WAIT_W-1:0] load_val_i,
  output logic              done_o
);

  logic [WAIT_W-1:0] cnt_q;

  // Count down to zero and hold there until reloaded
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= WAIT_W'(ResetVal);
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WAIT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/jtdd_sdram.sv
// SDRAM responder: serves 32-bit ROM reads, download writes and periodic refresh on bank 0.
module jtdd_sdram
  import jtdd_sdram_pkg::*;
#(
  parameter int unsigned INIT_WAIT  = 4800,
  parameter int unsigned REF_PERIOD = 374,
  parameter int unsigned TRP        = 2,
  parameter int unsigned TRCD       = 2,
  parameter int unsigned TRFC       = 4,
  parameter int unsigned CL         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic        data_rdy,
  output logic [31:0] data_read,
  output logic        loop_rst,
  input  logic        refresh_en,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  output logic        wr_busy,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [1:0]  sdram_dqm,
  output logic        sdram_ncs,
  output logic        sdram_nras,
  output logic        sdram_ncas,
  output logic        sdram_nwe,
  output logic        sdram_cke,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe
);

  state_e            state_q, state_d, ret_q, ret_d;
  logic              wait_load, wait_done;
  logic [WAIT_W-1:0] wait_val;
  logic [3:0]        cmd_q;
  logic [15:0]       ref_cnt_q;
  logic              ref_due;
  logic              wr_pend_q;
  logic [21:0]       wr_addr_q;
  logic [7:0]        wr_data_q, data_q;
  logic [1:0]        wr_mask_q, mask_q;
  logic              op_wr_q;
  logic [8:0]        col_q;
  logic [15:0]       lo_q;

  assign ref_due  = (ref_cnt_q >= 16'(REF_PERIOD)) && refresh_en;
  assign wr_busy  = wr_pend_q;
  assign sdram_ba = 2'b00;
  assign sdram_cke = 1'b1;
  assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd_q;

  // Wait lengths are loaded as (gap - 2): the command state and the final wait cycle each
  // take one cycle, so the next command lands exactly 'gap' cycles after this one.
  jtdd_sdram_wait #(
    .ResetVal (INIT_WAIT)
  ) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wait_load),
    .load_val_i (wait_val),
    .done_o     (wait_done)
  );

  // Next-state selection and wait-counter loading
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    wait_load = 1'b0;
    wait_val  = '0;
    unique case (state_q)
      StInitWait: if (wait_done) state_d = StInitPre;
      StInitPre: begin
        state_d = StWait; ret_d = StInitRef1; wait_load = 1'b1; wait_val = WAIT_W'(TRP - 2);
      end
      StInitRef1: begin
        state_d = StWait; ret_d = StInitRef2; wait_load = 1'b1; wait_val = WAIT_W'(TRFC - 2);
      end
      StInitRef2: begin
        state_d = StWait; ret_d = StMrs; wait_load = 1'b1; wait_val = WAIT_W'(TRFC - 2);
      end
      StMrs: begin
        state_d = StWait; ret_d = StIdle; wait_load = 1'b1; wait_val = '0;
      end
      StIdle: begin
        if (wr_pend_q)                         state_d = StAct;
        else if (ref_due)                      state_d = StRef;
        else if (sdram_req && !downloading)    state_d = StAct;
      end
      StAct: begin
        state_d = StWait; ret_d = op_wr_q ? StWrite : StRead;
        wait_load = 1'b1; wait_val = WAIT_W'(TRCD - 2);
      end
      // DATA0 is one cycle past CAS latency to allow for the registered dq_in path
      StRead: begin
        state_d = StWait; ret_d = StData0; wait_load = 1'b1; wait_val = WAIT_W'(CL - 1);
      end
      StData0:  state_d = StData1;
      StData1: begin
        state_d = StWait; ret_d = StIdle; wait_load = 1'b1; wait_val = WAIT_W'(TRP - 2);
      end
      StWrite:  state_d = StWrite2;
      StWrite2: begin
        state_d = StWait; ret_d = StIdle; wait_load = 1'b1; wait_val = WAIT_W'(TRP - 2);
      end
      StRef: begin
        state_d = StWait; ret_d = StIdle; wait_load = 1'b1; wait_val = WAIT_W'(TRFC - 2);
      end
      StWait:   if (wait_done) state_d = ret_q;
      default:  state_d = StInitWait;
    endcase
  end

  // State, registered SDRAM command/data outputs, write buffer and refresh counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInitWait;
      ret_q     <= StIdle;
      cmd_q     <= CMD_NOP;
      sdram_a   <= '0;
      sdram_dqm <= 2'b11;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      sdram_ack <= 1'b0;
      data_rdy  <= 1'b0;
      data_read <= '0;
      loop_rst  <= 1'b1;
      ref_cnt_q <= '0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
      op_wr_q   <= 1'b0;
      col_q     <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cmd_q     <= CMD_NOP;
      sdram_dqm <= 2'b11;
      dq_oe     <= 1'b0;
      sdram_ack <= 1'b0;
      data_rdy  <= 1'b0;

      if (state_d == StRef)                       ref_cnt_q <= '0;
      else if (ref_cnt_q < 16'(REF_PERIOD))       ref_cnt_q <= ref_cnt_q + 16'd1;

      // A strobe during the WRITE cycle refills the buffer rather than being lost
      if (prog_we) begin
        wr_pend_q <= 1'b1;
        wr_addr_q <= prog_addr;
        wr_data_q <= prog_data;
        wr_mask_q <= prog_mask;
      end else if (state_q == StWrite) begin
        wr_pend_q <= 1'b0;
      end

      if (state_d != state_q) begin
        case (state_d)
          StInitPre: begin
            cmd_q   <= CMD_PRE;
            sdram_a <= 13'h0400;
          end
          StInitRef1, StInitRef2, StRef: cmd_q <= CMD_REF;
          StMrs: begin
            cmd_q   <= CMD_MRS;
            sdram_a <= MODE_REG;
          end
          StIdle: loop_rst <= 1'b0;
          StAct: begin
            cmd_q <= CMD_ACT;
            if (wr_pend_q) begin
              op_wr_q <= 1'b1;
              col_q   <= wr_addr_q[8:0];
              data_q  <= wr_data_q;
              mask_q  <= wr_mask_q;
              sdram_a <= wr_addr_q[21:9];
            end else begin
              op_wr_q   <= 1'b0;
              col_q     <= sdram_addr[8:0];
              sdram_a   <= sdram_addr[21:9];
              sdram_ack <= 1'b1;
            end
          end
          StRead: begin
            cmd_q   <= CMD_RD;
            sdram_a <= col_addr(col_q);
          end
          StWrite: begin
            cmd_q     <= CMD_WR;
            sdram_a   <= col_addr(col_q);
            sdram_dqm <= mask_q;
            dq_oe     <= 1'b1;
            dq_out    <= {data_q, data_q};
          end
          StWrite2: dq_oe <= 1'b1;
          default: ;
        endcase
      end

      // Keep DQM low from READ through DATA0 so its read latency covers both beats
      if (state_d == StRead || state_d == StData0 || (state_d == StWait && ret_d == StData0)) begin
        sdram_dqm <= 2'b00;
      end

      if (state_q == StData0) lo_q <= dq_in;
      if (state_q == StData1) begin
        data_read <= {dq_in, lo_q};
        data_rdy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtdd_sdram.sv
// Self-checking bench for jtdd_sdram: init sequence, read/write vectors, refresh, reset abort.
module tb_jtdd_sdram;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst, downloading, sdram_req, refresh_en, prog_we;
  logic [21:0] sdram_addr, prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        sdram_ack, data_rdy, loop_rst, wr_busy;
  logic [31:0] data_read;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba, sdram_dqm;
  logic        sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe, sdram_cke;
  logic [15:0] dq_in = 16'h0000;
  logic [15:0] dq_out;
  logic        dq_oe;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_d0 = 16'h0000;
  logic [15:0] m_d1 = 16'h0000;
  logic [4:0]  rd_pipe = 5'd0;

  typedef struct {
    logic        wr;
    logic [21:0] addr;
    logic [7:0]  pdata;
    logic [1:0]  mask;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [12:0] row;
    logic [12:0] cola;
    logic [31:0] rdata;
    logic [1:0]  dqm;
    logic [15:0] dq;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  jtdd_sdram dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .loop_rst    (loop_rst),
    .refresh_en  (refresh_en),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .wr_busy     (wr_busy),
    .sdram_a     (sdram_a),
    .sdram_ba    (sdram_ba),
    .sdram_dqm   (sdram_dqm),
    .sdram_ncs   (sdram_ncs),
    .sdram_nras  (sdram_nras),
    .sdram_ncas  (sdram_ncas),
    .sdram_nwe   (sdram_nwe),
    .sdram_cke   (sdram_cke),
    .dq_in       (dq_in),
    .dq_out      (dq_out),
    .dq_oe       (dq_oe)
  );

  function automatic logic [3:0] cmd_now();
    return {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe};
  endfunction

  // SDRAM data model: first beat three cycles after the READ cycle, second beat one later
  always @(posedge clk) begin
    #2;
    rd_pipe = {rd_pipe[3:0], (cmd_now() == C_RD)};
    if (rd_pipe[3])      dq_in = m_d0;
    else if (rd_pipe[4]) dq_in = m_d1;
    else                 dq_in = 16'hDEAD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cmd(input logic [3:0] c, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (cmd_now() == c) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic init_seq();
    int n, g, rdy_seen;
    n = 0;
    rdy_seen = 0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (data_rdy) rdy_seen++;
      if (cmd_now() != C_NOP) break;
      n++;
    end
    chk("init_nop_cycles", 32'(n), 32'd4800);
    chk("init_pre_cmd", 32'({cmd_now(), sdram_a[10]}), 32'({C_PRE, 1'b1}));
    chk("init_no_data_rdy", 32'(rdy_seen), 32'd0);
    wait_cmd(C_REF, 20, g);
    chk("init_pre_to_ref1", 32'(g), 32'd2);
    wait_cmd(C_REF, 20, g);
    chk("init_ref1_to_ref2", 32'(g), 32'd4);
    wait_cmd(C_MRS, 20, g);
    chk("init_ref2_to_mrs", 32'(g), 32'd4);
    chk("init_mrs_a", 32'(sdram_a), 32'h021);
    chk("init_loop_rst_at_mrs", 32'(loop_rst), 32'd1);
    g = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!loop_rst) begin
        g = i;
        break;
      end
    end
    chk("init_loop_rst_fall", 32'(g), 32'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, rd_k, rdy_k, wr_k, ack_seen, refs, last_ref, max_gap, min_gap, bad_ack, acks_after;
    int ncmd;
    logic [12:0] rd_a, act_a, w_a;
    logic [1:0]  w_dqm, b2_dqm;
    logic [15:0] w_dq;
    logic        w_oe, b2_oe, b2_busy;
    logic [3:0]  seq [3];
    vec_t v;

    vecs[0] = '{wr: 1'b0, addr: 22'h012345, pdata: 8'h00, mask: 2'b00, d0: 16'hBEEF,
                d1: 16'hCAFE, row: 13'h0091, cola: 13'h0545, rdata: 32'hCAFEBEEF,
                dqm: 2'b00, dq: 16'h0000};
    vecs[1] = '{wr: 1'b1, addr: 22'h020000, pdata: 8'h5A, mask: 2'b10, d0: 16'h0000,
                d1: 16'h0000, row: 13'h0100, cola: 13'h0400, rdata: 32'h0,
                dqm: 2'b10, dq: 16'h5A5A};
    vecs[2] = '{wr: 1'b0, addr: 22'h3FFFFF, pdata: 8'h00, mask: 2'b00, d0: 16'h1234,
                d1: 16'h5678, row: 13'h1FFF, cola: 13'h05FF, rdata: 32'h56781234,
                dqm: 2'b00, dq: 16'h0000};
    vecs[3] = '{wr: 1'b1, addr: 22'h0001FF, pdata: 8'hA5, mask: 2'b01, d0: 16'h0000,
                d1: 16'h0000, row: 13'h0000, cola: 13'h05FF, rdata: 32'h0,
                dqm: 2'b01, dq: 16'hA5A5};
    vecs[4] = '{wr: 1'b0, addr: 22'h000000, pdata: 8'h00, mask: 2'b00, d0: 16'hFFFF,
                d1: 16'h0000, row: 13'h0000, cola: 13'h0400, rdata: 32'h0000FFFF,
                dqm: 2'b00, dq: 16'h0000};
    vecs[5] = '{wr: 1'b1, addr: 22'h2AAAAA, pdata: 8'h00, mask: 2'b00, d0: 16'h0000,
                d1: 16'h0000, row: 13'h1555, cola: 13'h04AA, rdata: 32'h0,
                dqm: 2'b00, dq: 16'h0000};

    rst = 1'b1; downloading = 1'b0; sdram_req = 1'b0; refresh_en = 1'b0; prog_we = 1'b0;
    sdram_addr = '0; prog_addr = '0; prog_data = '0; prog_mask = '0;
    repeat (3) tick();
    chk("rst_cmd", 32'(cmd_now()), 32'(C_NOP));
    chk("rst_cke_dqm_a", 32'({sdram_cke, sdram_dqm, sdram_a}), 32'({1'b1, 2'b11, 13'h0}));
    chk("rst_flags", 32'({dq_oe, sdram_ack, data_rdy, loop_rst, wr_busy}), 32'b00010);
    chk("rst_data_read", data_read, 32'h0);
    chk("rst_ba", 32'(sdram_ba), 32'd0);
    rst = 1'b0;
    init_seq();

    // Vector table: reads check address split, ack, latency and data; writes check the burst
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      if (!v.wr) begin
        m_d0 = v.d0; m_d1 = v.d1;
        sdram_addr = v.addr; sdram_req = 1'b1;
        wait_cmd(C_ACT, 40, g);
        chk($sformatf("v%0d_act_found", i), 32'(g > 0), 32'd1);
        chk($sformatf("v%0d_ack_in_act", i), 32'(sdram_ack), 32'd1);
        chk($sformatf("v%0d_act_row", i), 32'(sdram_a), 32'(v.row));
        sdram_req = 1'b0; sdram_addr = ~v.addr;
        rd_k = -1; rdy_k = -1; rd_a = '0;
        for (int k = 1; k <= 20; k++) begin
          tick();
          if (cmd_now() == C_RD) begin
            rd_k = k; rd_a = sdram_a;
          end
          if (data_rdy) begin
            rdy_k = k;
            break;
          end
        end
        chk($sformatf("v%0d_act_to_read", i), 32'(rd_k), 32'd2);
        chk($sformatf("v%0d_read_a", i), 32'(rd_a), 32'(v.cola));
        chk($sformatf("v%0d_ack_to_rdy", i), 32'(rdy_k), 32'd7);
        chk($sformatf("v%0d_data_read", i), data_read, v.rdata);
        tick();
        chk($sformatf("v%0d_rdy_pulse", i), 32'(data_rdy), 32'd0);
        chk($sformatf("v%0d_data_hold", i), data_read, v.rdata);
      end else begin
        downloading = 1'b1; sdram_req = 1'b1; sdram_addr = 22'h000003;
        prog_addr = v.addr; prog_data = v.pdata; prog_mask = v.mask; prog_we = 1'b1;
        tick();
        prog_we = 1'b0;
        chk($sformatf("v%0d_wr_busy_set", i), 32'(wr_busy), 32'd1);
        ack_seen = 0; wr_k = -1; act_a = '1; w_a = '0; w_dqm = '0; w_dq = '0; w_oe = 1'b0;
        b2_dqm = '0; b2_oe = 1'b0; b2_busy = 1'b1;
        for (int k = 1; k <= 30; k++) begin
          tick();
          if (sdram_ack) ack_seen++;
          if (cmd_now() == C_ACT) act_a = sdram_a;
          if (k == wr_k + 1) begin
            b2_dqm = sdram_dqm; b2_oe = dq_oe; b2_busy = wr_busy;
          end
          if (cmd_now() == C_WR) begin
            wr_k = k; w_a = sdram_a; w_dqm = sdram_dqm; w_dq = dq_out; w_oe = dq_oe;
          end
        end
        chk($sformatf("v%0d_busy_to_write", i), 32'(wr_k), 32'd3);
        chk($sformatf("v%0d_act_row", i), 32'(act_a), 32'(v.row));
        chk($sformatf("v%0d_write_a", i), 32'(w_a), 32'(v.cola));
        chk($sformatf("v%0d_write_dqm", i), 32'(w_dqm), 32'(v.dqm));
        chk($sformatf("v%0d_write_dq", i), 32'({w_oe, w_dq}), 32'({1'b1, v.dq}));
        chk($sformatf("v%0d_beat2_dqm_oe", i), 32'({b2_dqm, b2_oe}), 32'b111);
        chk($sformatf("v%0d_busy_cleared", i), 32'(b2_busy), 32'd0);
        chk($sformatf("v%0d_no_ack_downloading", i), 32'(ack_seen), 32'd0);
        downloading = 1'b0; sdram_req = 1'b0;
        tick();
      end
    end

    // Continuous reads with refresh enabled: refresh keeps its period, reads keep flowing
    refresh_en = 1'b1; sdram_req = 1'b1; sdram_addr = 22'h000100;
    refs = 0; last_ref = -1; max_gap = 0; min_gap = 100000; bad_ack = 0; acks_after = 0;
    for (int c = 0; c < 1200; c++) begin
      tick();
      if (cmd_now() == C_REF) begin
        refs++;
        if (last_ref >= 0) begin
          if (c - last_ref > max_gap) max_gap = c - last_ref;
          if (c - last_ref < min_gap) min_gap = c - last_ref;
        end
        last_ref = c;
      end
      if (sdram_ack && cmd_now() != C_ACT) bad_ack++;
      if (sdram_ack && refs > 0) acks_after++;
    end
    chk("ref_count_ge3", 32'(refs >= 3), 32'd1);
    chk("ref_max_gap_le_384", 32'(max_gap <= 384), 32'd1);
    chk("ref_min_gap_ge_375", 32'(min_gap >= 375), 32'd1);
    chk("ref_reads_resume", 32'(acks_after > 0), 32'd1);
    chk("ref_ack_only_on_act", 32'(bad_ack), 32'd0);
    sdram_req = 1'b0; refresh_en = 1'b0;
    repeat (20) tick();

    // Write pending and refresh due in the same IDLE cycle: write goes first
    repeat (380) tick();
    prog_addr = 22'h000055; prog_data = 8'h11; prog_mask = 2'b00; prog_we = 1'b1;
    tick();
    prog_we = 1'b0; refresh_en = 1'b1;
    ncmd = 0;
    seq[0] = C_NOP; seq[1] = C_NOP; seq[2] = C_NOP;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (cmd_now() != C_NOP && ncmd < 3) begin
        seq[ncmd] = cmd_now();
        ncmd++;
      end
    end
    chk("coll_first_act", 32'(seq[0]), 32'(C_ACT));
    chk("coll_then_write", 32'(seq[1]), 32'(C_WR));
    chk("coll_then_ref", 32'(seq[2]), 32'(C_REF));
    refresh_en = 1'b0;
    repeat (10) tick();

    // Reset during the CAS-latency wait aborts the read and restarts initialisation
    m_d0 = 16'h1111; m_d1 = 16'h2222;
    sdram_addr = 22'h000777; sdram_req = 1'b1;
    wait_cmd(C_ACT, 40, g);
    chk("abort_act_found", 32'(g > 0), 32'd1);
    sdram_req = 1'b0;
    wait_cmd(C_RD, 10, g);
    chk("abort_read_gap", 32'(g), 32'd2);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_cmd_nop", 32'(cmd_now()), 32'(C_NOP));
    chk("abort_flags", 32'({loop_rst, data_rdy, dq_oe, sdram_dqm}), 32'b10011);
    rst = 1'b0;
    init_seq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
